// File: rtl/game_pkg.sv
// game_pkg: shared screen geometry, colours, FSM states and helpers for the game
package game_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BALL_WIDTH = 5;
  localparam int HALF = BALL_WIDTH / 2;
  localparam logic [5:0] COL_BLACK = 6'h00;
  localparam logic [5:0] COL_WHITE = 6'h3f;
  localparam logic [5:0] COL_RED = 6'h30;
  localparam logic [5:0] COL_GREEN = 6'h0c;
  localparam logic [5:0] COL_BLUE = 6'h03;
  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    LOST  = 2'd2
  } state_t;
  function automatic logic signed [10:0] clamp11(input logic signed [10:0] v,
                                                 input logic signed [10:0] lo,
                                                 input logic signed [10:0] hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction
endpackage

// File: rtl/ball_collision_latch.sv
// ball_collision_latch: sticky per-frame bounce flags gathered from painter overlaps
module ball_collision_latch
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       in_ball,
  input  logic       in_paddle,
  input  logic       in_brick,
  output logic       hflip,
  output logic       vflip,
  output logic       pad_hit
);
  logic r_hflip, r_vflip, r_pad_hit;
  logic w_hit, w_hedge, w_vedge;
  assign w_hit = in_ball & (in_paddle | in_brick);
  assign w_hedge = (hpos == x - 10'(HALF)) || (hpos == x + 10'(HALF));
  assign w_vedge = (vpos == y - 9'(HALF)) || (vpos == y + 9'(HALF));
  // outputs include the current pixel so a hit on the frame_end cycle is consumed immediately
  assign hflip = r_hflip | (w_hit & w_hedge);
  assign vflip = r_vflip | (w_hit & w_vedge);
  assign pad_hit = r_pad_hit | (in_ball & in_paddle);
  // accumulate flags until cleared at frame_end or outside play
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_hflip <= 1'b0;
      r_vflip <= 1'b0;
      r_pad_hit <= 1'b0;
    end else begin
      r_hflip <= hflip;
      r_vflip <= vflip;
      r_pad_hit <= pad_hit;
    end
  end
endmodule

// File: rtl/ball_controller.sv
// ball_controller: ball position, per-frame motion, bounces and serve/lost flow
module ball_controller
  import game_pkg::*;
#(
  parameter int SERVE_Y = 400,
  parameter int SPEED = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic       in_ball,
  input  logic       in_paddle,
  input  logic       in_brick,
  input  logic [9:0] paddle_x,
  input  logic       launch,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       lost,
  output logic       playing
);
  localparam int XMAX = SCREEN_W - 1 - HALF;
  localparam int YMAX = SCREEN_H - 1 - HALF;
  localparam logic signed [10:0] STEP = 11'(SPEED);
  state_t r_state;
  logic [9:0] r_x;
  logic [8:0] r_y;
  logic r_dx_pos, r_dy_pos, r_lost, r_playing;
  logic w_hflip, w_vflip, w_pad_hit, w_dx_pos, w_dy_pos, w_lose;
  logic signed [10:0] w_x_sum, w_y_sum;
  logic [9:0] w_x_nxt, w_pad_x;
  logic [8:0] w_y_nxt;
  ball_collision_latch u_latch (
    .clk      (clk),
    .reset    (reset),
    .clear    (frame_end || r_state != PLAY),
    .hpos     (hpos),
    .vpos     (vpos),
    .x        (r_x),
    .y        (r_y),
    .in_ball  (in_ball),
    .in_paddle(in_paddle),
    .in_brick (in_brick),
    .hflip    (w_hflip),
    .vflip    (w_vflip),
    .pad_hit  (w_pad_hit)
  );
  // next direction and position; wall rules override collision flips
  always_comb begin
    w_dx_pos = (r_x <= 10'(HALF + SPEED)) ? 1'b1 : (r_x >= 10'(XMAX - SPEED)) ? 1'b0 : r_dx_pos ^ w_hflip;
    w_dy_pos = (r_y <= 9'(HALF + SPEED)) ? 1'b1 : w_pad_hit ? 1'b0 : r_dy_pos ^ w_vflip;
    w_lose = (r_y >= 9'(YMAX - SPEED)) && !w_pad_hit;
    w_x_sum = $signed({1'b0, r_x}) + (w_dx_pos ? STEP : -STEP);
    w_y_sum = $signed({2'b0, r_y}) + (w_dy_pos ? STEP : -STEP);
    w_x_nxt = 10'(clamp11(w_x_sum, 11'(HALF), 11'(XMAX)));
    w_y_nxt = 9'(clamp11(w_y_sum, 11'(HALF), 11'(YMAX)));
    w_pad_x = 10'(clamp11($signed({1'b0, paddle_x}), 11'(HALF), 11'(XMAX)));
  end
  // game flow FSM; position only moves on frame_end so it is stable during the visible frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SERVE;
      r_x <= 10'(SCREEN_W / 2);
      r_y <= 9'(SERVE_Y);
      r_dx_pos <= 1'b1;
      r_dy_pos <= 1'b0;
      r_lost <= 1'b0;
      r_playing <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      case (r_state)
        SERVE: if (frame_end) begin
          r_x <= w_pad_x;
          r_y <= 9'(SERVE_Y);
          if (launch) begin
            r_state <= PLAY;
            r_playing <= 1'b1;
            r_dx_pos <= 1'b1;
            r_dy_pos <= 1'b0;
          end
        end
        PLAY: if (frame_end) begin
          r_dx_pos <= w_dx_pos;
          r_dy_pos <= w_dy_pos;
          if (w_lose) begin
            r_state <= LOST;
            r_lost <= 1'b1;
            r_playing <= 1'b0;
          end else begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
          end
        end
        default: begin
          r_state <= SERVE;
          r_playing <= 1'b0;
        end
      endcase
    end
  end
  assign x = r_x;
  assign y = r_y;
  assign lost = r_lost;
  assign playing = r_playing;
endmodule
